// File: rtl/rom_word_serializer.sv
// rom_word_serializer
//
// Takes full DATA_WIDTH words from the ROM fetch stage over a valid/ready
// handshake and emits them as a stream of CHUNK_WIDTH chunks, one chunk per
// cycle, with no bubble between consecutive words. The final chunk of each
// word is flagged with out_last, and completed words are counted.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   in_data    word from the ROM fetch stage
//   in_valid   in_data is valid this cycle
//   in_ready   serializer can take a word this cycle (combinational)
//   out_data   current chunk (registered)
//   out_valid  out_data is valid (registered)
//   out_ready  downstream accepts the chunk
//   out_last   out_data is the final chunk of its word (registered)
//   word_cnt   number of words fully emitted, modulo 2^CNT_WIDTH
//   busy       a word is being emitted (same as out_valid)
module rom_word_serializer #(
  parameter int DATA_WIDTH  = 32,
  parameter int CHUNK_WIDTH = 8,
  parameter int MSB_FIRST   = 1,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DATA_WIDTH-1:0]  in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [CHUNK_WIDTH-1:0] out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_last,
  output logic [CNT_WIDTH-1:0]   word_cnt,
  output logic                   busy
);

  localparam int NCHUNK = DATA_WIDTH / CHUNK_WIDTH;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_SHIFT = 1'b1;

  generate
    if ((NCHUNK < 2) || (DATA_WIDTH % CHUNK_WIDTH != 0)) begin : g_bad_params
      $error("rom_word_serializer: DATA_WIDTH must be a multiple of CHUNK_WIDTH with at least 2 chunks");
    end
  endgenerate

  logic [0:0]            state;
  logic [IDX_W-1:0]      idx;
  logic [DATA_WIDTH-1:0] word;

  logic at_last;
  logic in_fire;
  logic out_fire;

  // Chunk k of a word in emission order.
  function automatic logic [CHUNK_WIDTH-1:0] chunk_of(input logic [DATA_WIDTH-1:0] w,
                                                      input int k);
    if (MSB_FIRST != 0) return w[DATA_WIDTH-1-k*CHUNK_WIDTH -: CHUNK_WIDTH];
    else                return w[k*CHUNK_WIDTH +: CHUNK_WIDTH];
  endfunction

  assign at_last  = (idx == LAST_IDX);
  assign out_fire = out_valid && out_ready;
  assign in_fire  = in_valid && in_ready;
  assign busy     = out_valid;

  // A new word can be taken when nothing is held, or when the last chunk of
  // the held word leaves this very cycle; that overlap is what removes the
  // bubble between words.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path through the block leaves it unassigned and infers a latch.
    in_ready = 1'b0;
    if (!rst) begin
      case (state)
        S_IDLE:  in_ready = 1'b1;
        S_SHIFT: in_ready = at_last && out_ready;
        default: in_ready = 1'b0;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      idx       <= '0;
      word      <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      word_cnt  <= '0;
    end else begin
      if (in_fire) begin
        // Load from IDLE, or chain straight behind the last chunk.
        state     <= S_SHIFT;
        word      <= in_data;
        idx       <= '0;
        out_data  <= chunk_of(in_data, 0);
        out_valid <= 1'b1;
        out_last  <= 1'b0;
      end else if (out_fire) begin
        if (at_last) begin
          state     <= S_IDLE;
          idx       <= '0;
          out_valid <= 1'b0;
          out_last  <= 1'b0;
        end else begin
          idx      <= idx + 1'b1;
          out_data <= chunk_of(word, int'(idx) + 1);
          out_last <= ((idx + 1'b1) == LAST_IDX);
        end
      end

      if (out_fire && at_last) word_cnt <= word_cnt + 1'b1;
    end
  end

endmodule

// File: doc/rom_word_serializer.md
Name: rom_word_serializer

Overview:
Downstream consumer of the ROM fetch stage. It accepts full DATA_WIDTH words from the ROM data lines via a valid/ready handshake and emits them as a stream of CHUNK_WIDTH chunks, for example bytes for a UART or display path. It also flags the last chunk of each word and counts completed words. Throughput is one chunk per cycle, with no bubble between consecutive words.

Parameters:
DATA_WIDTH, 32, width of input word; must be an integer multiple of CHUNK_WIDTH
CHUNK_WIDTH, 8, width of each output chunk
MSB_FIRST, 1, 1 = most-significant chunk emitted first; 0 = least-significant first
CNT_WIDTH, 16, width of completed-word counter
Derived: NCHUNK = DATA_WIDTH/CHUNK_WIDTH, which must be >= 2 (elaboration error otherwise).

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
in_data  input  DATA_WIDTH  word from ROM fetch stage
in_valid  input  1  in_data valid this cycle
in_ready  output  1  serializer can take a word this cycle
out_data  output  CHUNK_WIDTH  current chunk
out_valid  output  1  out_data valid
out_ready  input  1  downstream accepts chunk
out_last  output  1  out_data is final chunk of its word
word_cnt  output  CNT_WIDTH  number of words fully emitted, modulo 2^CNT_WIDTH
busy  output  1  equals out_valid

Behaviour:
- Handshakes: an input transfer occurs when in_valid && in_ready at a rising edge. An output transfer occurs when out_valid && out_ready at a rising edge.
- States:
  - IDLE: no word held.
  - SHIFT: word held; chunk index idx runs 0..NCHUNK-1.
- in_ready is combinational: 1 in IDLE; 1 in SHIFT only when idx==NCHUNK-1 && out_ready; 0 otherwise. It is forced to 0 while rst is high.
- IDLE + input transfer -> SHIFT: load word, idx=0, out_valid=1 from the next cycle. Latency is 1 cycle, word accept to first chunk visible.
- SHIFT + output transfer with idx<NCHUNK-1: idx+1, next chunk presented the following cycle.
- SHIFT + output transfer with idx==NCHUNK-1:
  - word_cnt increments.
  - If an input transfer occurs in the same cycle, load the new word, idx=0, stay in SHIFT. There is no bubble.
  - Otherwise go to IDLE and set out_valid=0.
- Chunk order:
  - MSB_FIRST=1: chunk idx = in_data[DATA_WIDTH-1-idx*CHUNK_WIDTH -: CHUNK_WIDTH].
  - MSB_FIRST=0: chunk idx = in_data[idx*CHUNK_WIDTH +: CHUNK_WIDTH].
- out_data, out_valid and out_last are registered outputs, not combinational from in_data.
- out_last = out_valid && idx==NCHUNK-1.
- Stall: while out_valid && !out_ready, out_data, out_last and idx hold exactly. in_data changes are ignored while no input transfer occurs.
- word_cnt wraps from all-ones to 0 silently.
- Reset, at any time including mid-word:
  - Reset values: state IDLE, idx 0, out_data 0, out_valid 0, out_last 0, word_cnt 0.
  - The partially emitted word is discarded.
  - The first rising edge after rst deasserts may accept a word.
- Input transfers in the same cycle as rst deassertion edge are ignored.

Test Plan:
1. Reset, then one word 0xA1B2C3D4 with out_ready=1 -> out_data A1,B2,C3,D4 on 4 consecutive cycles starting 1 cycle after accept; out_last only on D4; word_cnt 0->1; in_ready high during the D4 cycle.
2. Back-to-back words 0x01020304, 0x05060708 with in_valid held high and out_ready=1 -> 8 contiguous chunks 01..08 with no gap; in_ready pulses only on the last-chunk cycles; word_cnt=2.
3. Backpressure: word 0xDEADBEEF, out_ready low for 3 cycles while BE is presented -> BE held stable with out_valid=1; then EF follows; no chunk lost or duplicated.
4. Reset mid-word: assert rst after AA of 0xAABBCCDD -> out_valid=0, out_data=0, word_cnt=0 immediately (async); after release, word 0x11223344 emits 11,22,33,44 cleanly.
5. MSB_FIRST=0 with word 0xA1B2C3D4 -> D4,C3,B2,A1; out_last on A1.
6. CNT_WIDTH=2: feed 5 words -> word_cnt sequence 1,2,3,0,1.
